// File: rtl/sequenciador_regras_ativas_pkg.sv
// Shared definitions for the active-rule sequencer.
// The inference unit uses the same rule-index function.
package sequenciador_regras_ativas_pkg;

  localparam int N_CONJ_PAD  = 3;
  localparam int W_REGRA_PAD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LIMPA = 3'd1,
    EMITE = 3'd2,
    FIM   = 3'd3
  } estado_t;

  function automatic int indice_regra(
    input int n_conj,
    input int i,
    input int j
  );
    return n_conj * i + j;
  endfunction

endpackage

// File: rtl/sequenciador_regras_ativas_codificador.sv
// Lowest-set-bit encoder over the pending-rule vector.
// The lowest index wins, so rules come out in ascending order.
module codificador_prioridade_regras #(
  parameter int N_BITS = 9,
  parameter int W      = 4
) (
  input  logic [N_BITS-1:0] bits,
  output logic [W-1:0]      indice,
  output logic              algum
);

  always_comb begin
    indice = '0;
    for (int k = N_BITS - 1; k >= 0; k--) begin
      if (bits[k]) indice = W'(k);
    end
  end

  assign algum = |bits;

endmodule

// File: rtl/sequenciador_regras_ativas.sv
// Walks only the active rules, one per handshake,
// with a clear pulse before and an end pulse after each pass.
module sequenciador_regras_ativas
  import sequenciador_regras_ativas_pkg::*;
#(
  parameter int N_CONJ  = N_CONJ_PAD,
  parameter int W_REGRA = W_REGRA_PAD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EN_REGRAS,
  input  logic [2*N_CONJ-1:0] FOU_ativo,
  input  logic                regra_pronta,
  output logic [W_REGRA-1:0]  Sequencia_regras,
  output logic                regra_valida,
  output logic                Reset_Inf,
  output logic                fim,
  output logic                ocupado,
  output logic [W_REGRA-1:0]  num_regras,
  output logic [2:0]          estado
);

  localparam int N_REGRAS = N_CONJ * N_CONJ;
  localparam logic [W_REGRA-1:0] MAX_REGRAS =
    W_REGRA'(N_REGRAS);

  if ((2 ** W_REGRA) < N_REGRAS) begin : g_param_ilegal
    $error("W_REGRA too narrow for N_CONJ*N_CONJ rules");
  end

  estado_t               estado_q, estado_d;
  logic [N_REGRAS-1:0]   pend_q, pend_d;
  logic [N_REGRAS-1:0]   pend_novo, um_quente;
  logic [W_REGRA-1:0]    idx, num_q;
  logic                  algum, transf;

  codificador_prioridade_regras #(
    .N_BITS (N_REGRAS),
    .W      (W_REGRA)
  ) u_codificador (
    .bits   (pend_q),
    .indice (idx),
    .algum  (algum)
  );

  always_comb begin
    pend_novo = '0;
    for (int i = 0; i < N_CONJ; i++) begin
      for (int j = 0; j < N_CONJ; j++) begin
        pend_novo[indice_regra(N_CONJ, i, j)] =
          FOU_ativo[i] & FOU_ativo[N_CONJ+j];
      end
    end
  end

  assign um_quente = N_REGRAS'(1) << idx;
  assign transf    = (estado_q == EMITE) & regra_pronta;

  always_comb begin
    estado_d = estado_q;
    pend_d   = pend_q;
    case (estado_q)
      IDLE: begin
        if (EN_REGRAS) begin
          pend_d   = pend_novo;
          estado_d = LIMPA;
        end
      end
      LIMPA: estado_d = algum ? EMITE : FIM;
      EMITE: begin
        if (transf) begin
          pend_d = pend_q & ~um_quente;
          if (pend_d == '0) estado_d = FIM;
        end
      end
      FIM: estado_d = IDLE;
      default: begin
        estado_d = IDLE;
        pend_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= IDLE;
      pend_q   <= '0;
      num_q    <= '0;
    end else begin
      estado_q <= estado_d;
      pend_q   <= pend_d;
      if ((estado_q == IDLE) && EN_REGRAS) begin
        num_q <= '0;
      end else if (transf && (num_q < MAX_REGRAS)) begin
        num_q <= num_q + 1'b1;
      end
    end
  end

  assign regra_valida     = (estado_q == EMITE);
  assign Sequencia_regras = regra_valida ? idx : '0;
  assign Reset_Inf        = (estado_q == LIMPA);
  assign fim              = (estado_q == FIM);
  assign ocupado          = (estado_q != IDLE);
  assign num_regras       = num_q;
  assign estado           = estado_q;

endmodule

// File: tb/tb_sequenciador_regras_ativas.sv
// Randomized bench for the active-rule sequencer against
// a rule-list model built from the activation flags.
module tb_sequenciador_regras_ativas;

  logic       clk = 1'b0;
  logic       rst;
  logic       EN_REGRAS;
  logic [5:0] FOU_ativo;
  logic       regra_pronta;
  logic [3:0] Sequencia_regras;
  logic       regra_valida;
  logic       Reset_Inf;
  logic       fim;
  logic       ocupado;
  logic [3:0] num_regras;
  logic [2:0] estado;

  int checks = 0;
  int erros  = 0;

  always #5 clk = ~clk;

  sequenciador_regras_ativas dut (
    .clk              (clk),
    .rst              (rst),
    .EN_REGRAS        (EN_REGRAS),
    .FOU_ativo        (FOU_ativo),
    .regra_pronta     (regra_pronta),
    .Sequencia_regras (Sequencia_regras),
    .regra_valida     (regra_valida),
    .Reset_Inf        (Reset_Inf),
    .fim              (fim),
    .ocupado          (ocupado),
    .num_regras       (num_regras),
    .estado           (estado)
  );

  task automatic verifica(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] esp
  );
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s obs=%0d esp=%0d", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic saidas_zero(input string tag);
    verifica({tag, "_estado"}, estado, 0);
    verifica({tag, "_valida"}, regra_valida, 0);
    verifica({tag, "_seq"}, Sequencia_regras, 0);
    verifica({tag, "_rinf"}, Reset_Inf, 0);
    verifica({tag, "_fim"}, fim, 0);
    verifica({tag, "_ocup"}, ocupado, 0);
    verifica({tag, "_num"}, num_regras, 0);
  endtask

  // modo: 0 always ready, 1 random ready, 2 stall 3 cycles on rule 4
  task automatic run_pass(
    input logic [5:0] fou,
    input int         modo,
    input bit         baguncar
  );
    int   esp[$];
    int   k;
    int   ciclos;
    int   stall;
    logic p;
    for (int r = 0; r < 9; r++) begin
      if (fou[r/3] && fou[3 + r%3]) esp.push_back(r);
    end
    k = esp.size();
    EN_REGRAS = 1'b1;
    FOU_ativo = fou;
    ciclo();
    EN_REGRAS = 1'b0;
    verifica("limpa_rinf", Reset_Inf, 1);
    verifica("limpa_ocup", ocupado, 1);
    verifica("limpa_num", num_regras, 0);
    verifica("limpa_valida", regra_valida, 0);
    verifica("limpa_seq", Sequencia_regras, 0);
    ciclo();
    ciclos = 0;
    stall  = 0;
    while (esp.size() > 0) begin
      if (ciclos > 60) begin
        verifica("timeout", 1, 0);
        break;
      end
      verifica("valida", regra_valida, 1);
      verifica("seq", Sequencia_regras, esp[0]);
      verifica("rinf_emite", Reset_Inf, 0);
      verifica("fim_emite", fim, 0);
      case (modo)
        0: p = 1'b1;
        1: p = 1'($urandom_range(0, 1));
        default: begin
          if (esp[0] == 4 && stall < 3) begin
            p = 1'b0;
            stall++;
          end else begin
            p = 1'b1;
          end
        end
      endcase
      regra_pronta = p;
      if (baguncar) begin
        FOU_ativo = 6'($urandom);
        EN_REGRAS = 1'($urandom);
      end
      ciclo();
      ciclos++;
      if (p) void'(esp.pop_front());
    end
    EN_REGRAS    = 1'b0;
    regra_pronta = 1'($urandom_range(0, 1));
    verifica("fim", fim, 1);
    verifica("fim_num", num_regras, k);
    verifica("fim_valida", regra_valida, 0);
    verifica("fim_estado", estado, 3);
    if (modo == 2) verifica("stall", stall, 3);
    ciclo();
    verifica("idle_estado", estado, 0);
    verifica("idle_ocup", ocupado, 0);
    verifica("idle_fim", fim, 0);
    verifica("idle_num", num_regras, k);
  endtask

  initial begin
    rst          = 1'b0;
    EN_REGRAS    = 1'b0;
    FOU_ativo    = '0;
    regra_pronta = 1'b0;
    ciclo();
    ciclo();
    saidas_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    ciclo();
    saidas_zero("pos_reset");

    run_pass(6'b001_001, 0, 0);
    run_pass(6'b011_011, 0, 0);
    run_pass(6'b111_000, 0, 0);
    run_pass(6'b111_111, 2, 0);
    run_pass(6'b101_110, 0, 1);

    // EN held high re-triggers from IDLE
    EN_REGRAS = 1'b1;
    FOU_ativo = 6'b111_000;
    ciclo();
    verifica("retrig_rinf1", Reset_Inf, 1);
    ciclo();
    verifica("retrig_fim", fim, 1);
    ciclo();
    verifica("retrig_idle", estado, 0);
    ciclo();
    verifica("retrig_rinf2", Reset_Inf, 1);
    EN_REGRAS = 1'b0;
    ciclo();
    verifica("retrig_fim2", fim, 1);
    ciclo();

    // abort mid-pass with async reset
    EN_REGRAS    = 1'b1;
    FOU_ativo    = 6'b111_111;
    regra_pronta = 1'b1;
    ciclo();
    EN_REGRAS = 1'b0;
    ciclo();
    ciclo();
    ciclo();
    verifica("abort_seq", Sequencia_regras, 2);
    #2;
    rst = 1'b0;
    #1;
    saidas_zero("abort");
    for (int c = 0; c < 3; c++) begin
      ciclo();
      verifica("abort_fim", fim, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    ciclo();
    saidas_zero("abort_rel");
    run_pass(6'b111_111, 0, 0);

    for (int n = 0; n < 30; n++) begin
      run_pass(6'($urandom), 1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
